// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide engine.
package muldiv_pkg;

  localparam int XLEN_P = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN_P-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN_P-1:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic op_a_signed(input logic [2:0] f3);
    return f3 inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(input logic [2:0] f3);
    return f3 inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage handshake between the pipeline and the multiply/divide engine.
interface muldiv_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            stall;
  logic [XLEN-1:0] result;
  logic            done;

  modport master (output start, funct3, op_a, op_b, flush,
                  input  stall, result, done);
  modport slave  (input  start, funct3, op_a, op_b, flush,
                  output stall, result, done);
endinterface

// File: rtl/muldiv_iter.sv
// One shift-add (multiply) or restoring trial-subtract (divide) step on the
// shared {hi, lo} accumulator.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;
  logic            fits;

  always_comb begin
    sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
    rem_sh = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    fits   = rem_sh >= {1'b0, opnd_i};
    // The difference is below the divisor whenever it is used, so XLEN bits suffice.
    diff   = rem_sh[XLEN-1:0] - opnd_i;
    if (is_div_i) begin
      acc_o = {(fits ? diff : rem_sh[XLEN-1:0]), acc_i[XLEN-2:0], fits};
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine; stalls the pipeline until the result
// is ready, then presents it for one cycle.
//   state | meaning
//   IDLE  | waiting for start; a start here stalls and latches operands
//   BUSY  | one iteration per cycle, 32 iterations
//   DONE  | result valid for one cycle, stall released
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_init, acc_iter, prod;
  logic [XLEN-1:0]   opnd_q, opnd_init, result_q;
  logic [XLEN-1:0]   mag_a, mag_b, special_res, final_res, quot, rem;
  logic [2:0]        f3_q;
  logic              neg_q, neg_rem_q;
  logic              sign_a, sign_b, div_zero, div_ovf, is_special;
  logic              accept, last_iter;

  always_comb begin
    sign_a     = bus.op_a[XLEN-1] & op_a_signed(bus.funct3);
    sign_b     = bus.op_b[XLEN-1] & op_b_signed(bus.funct3);
    mag_a      = sign_a ? -bus.op_a : bus.op_a;
    mag_b      = sign_b ? -bus.op_b : bus.op_b;
    div_zero   = bus.funct3[2] && (bus.op_b == '0);
    div_ovf    = bus.funct3[2] && !bus.funct3[0] && (bus.op_a == INT_MIN) && (bus.op_b == '1);
    is_special = div_zero || div_ovf;
    if (div_zero) begin
      special_res = bus.funct3[1] ? bus.op_a : DIV0_QUOT;
    end else begin
      special_res = bus.funct3[1] ? '0 : INT_MIN;
    end
    // Divide keeps {remainder, dividend}; multiply keeps {product_hi, multiplier}.
    if (bus.funct3[2]) begin
      acc_init  = {{XLEN{1'b0}}, mag_a};
      opnd_init = mag_b;
    end else begin
      acc_init  = {{XLEN{1'b0}}, mag_b};
      opnd_init = mag_a;
    end
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .is_div_i (f3_q[2]),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_iter)
  );

  always_comb begin
    prod = neg_q ? -acc_iter : acc_iter;
    quot = acc_iter[XLEN-1:0];
    rem  = acc_iter[2*XLEN-1:XLEN];
    case (f3_q)
      OP_MUL:                        final_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               final_res = neg_q ? -quot : quot;
      default:                       final_res = neg_rem_q ? -rem : rem;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    accept    = (state_q == IDLE) && bus.start && !bus.flush;
    last_iter = (state_q == BUSY) && (cnt_q == CNT_W'(XLEN-1));
    case (state_q)
      IDLE:    if (bus.start) state_d = is_special ? DONE : BUSY;
      BUSY:    if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      f3_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else if (accept) begin
      if (is_special) begin
        result_q <= special_res;
      end else begin
        cnt_q     <= '0;
        acc_q     <= acc_init;
        opnd_q    <= opnd_init;
        f3_q      <= bus.funct3;
        neg_q     <= sign_a ^ sign_b;
        neg_rem_q <= sign_a;
      end
    end else if ((state_q == BUSY) && !bus.flush) begin
      acc_q <= acc_iter;
      cnt_q <= cnt_q + 1'b1;
      if (last_iter) result_q <= final_res;
    end
  end

  assign bus.stall  = rst_n && !bus.flush &&
                      (((state_q == IDLE) && bus.start) || (state_q == BUSY));
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide engine in the EX stage.
- Accepts an M-extension operation from the ID/EX register and runs a 32-step shift-add (MUL*) or restoring-division (DIV*/REM*) sequence.
- Drives the `stall` input of the hazard unit. While `stall` is high, PC, IF/ID and ID/EX are frozen and the operation stays presented.
- Presents the final result for exactly one cycle with `stall` low, so EX/MEM captures it.

Parameters:
- XLEN, 32: operand/result width. Only 32 is supported.
- CNT_W, 5: iteration counter width, equal to log2(XLEN).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  ID/EX holds a valid M-extension instruction. Held high for the whole stall.
- funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value, after forwarding.
- op_b  in  XLEN  rs2 value, after forwarding.
- flush  in  1  jump/branch-taken flush of the EX stage.
- stall  out  1  to hazard_unit.stall; high while the result is not ready.
- result  out  XLEN  result, valid only when done=1.
- done  out  1  result valid this cycle.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, counter=0, all datapath registers 0, result=0, done=0. `stall` is forced 0 while rst_n is low.
- State machine:
  - IDLE, start=1, flush=0, no special case: latch op_a/op_b magnitudes, sign flags and funct3; counter=0; go to BUSY.
  - IDLE, start=1, flush=0, special division case: go directly to DONE with the fixed result.
  - IDLE, start=0: stay in IDLE.
  - BUSY: perform one iteration per cycle. After the 32nd iteration (counter=31), go to DONE.
  - DONE: done=1, result driven from the result register; unconditionally go to IDLE. The instruction leaves EX at this edge.
  - DONE never restarts, even though start is still high in that cycle.
- Stall: stall = ((IDLE && start) || BUSY) && !flush. This is combinational, so the first EX cycle already stalls.
- Latency, normal ops: stall high for 33 cycles (1 IDLE + 32 BUSY), then 1 DONE cycle.
- Latency, special cases: stall high for 1 cycle, then DONE.
- Multiply:
  - Unsigned 32x32 shift-add on magnitudes into a 64-bit accumulator, 1 multiplier bit per cycle.
  - Signedness: op_a is signed for MUL/MULH/MULHSU; op_b is signed for MUL/MULH.
  - Negate the 64-bit product if the operand signs differ.
  - Select: MUL gives product[31:0]; MULH/MULHSU/MULHU give product[63:32].
- Divide:
  - Restoring division on magnitudes, 1 quotient bit per cycle.
  - Operands are signed for DIV/REM.
  - Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
- Special cases (RISC-V defined, no trap):
  - Divisor 0: quotient = 0xFFFFFFFF, remainder = op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- Flush:
  - flush=1 in any state forces next state IDLE and masks stall in that cycle.
  - The partial result is discarded and done stays 0.
  - flush has priority over start.
- Operand stability: op_a, op_b and funct3 are sampled only on the IDLE→BUSY transition. Later changes are ignored.
- Back-to-back: a new M instruction entering EX the cycle after DONE is accepted from IDLE. No bubble is required beyond the IDLE start cycle.
- Reset mid-operation: return to IDLE immediately; result/done are cleared.

Decomposition:
- Package muldiv_pkg:
  - funct3 op localparams (OP_MUL … OP_REMU).
  - state enum {IDLE, BUSY, DONE}.
  - special-case constants DIV0_QUOT, INT_MIN.
- Sub-module muldiv_iter: one-iteration combinational step (shift-add or trial subtract). Instantiated once; the top holds the FSM, counter and sign fixup.

Test Plan:
- MUL 7 × -3 → stall high 33 cycles, then done=1 with result=0xFFFFFFEB.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → result=0xFFFFFFFE.
- MULHSU 0xFFFFFFFF (-1) × 2 → result=0xFFFFFFFF.
- DIV -7 / 2 → result=0xFFFFFFFD (-3).
- REM -7 / 2 → result=0xFFFFFFFF (-1).
- DIVU 5 / 0 → stall 1 cycle, result=0xFFFFFFFF.
- REM 5 / 0 → result=5.
- DIV 0x80000000 / 0xFFFFFFFF → result=0x80000000.
- REM with the same operands → result=0.
- Flush abort:
  - Start DIVU 100/3, assert flush at BUSY counter=10 → stall=0 that cycle, state IDLE next, done never asserted.
  - Immediately restart DIVU 100/3 → result=33 after 33 stall cycles.
- Back-to-back MUL 6×7 then REMU 17/5 with start held continuously → done pulses once per op; results 42 then 2.
- Reset: assert rst_n=0 mid-BUSY → stall=0, done=0, result=0 asynchronously.
